// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode constants and forwarding-select encodings for the hazard scoreboard.
// Also holds the priority rule used to pick an EX operand source.
package hazard_scoreboard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_ALU = 2'b01,
        FWD_LD  = 2'b10
    } fwd_sel_e;

    // ALU result in EX/MEM wins over a load completing in MEM/WB.
    function automatic fwd_sel_e fwd_select(
        input logic src_used,
        input logic src_zero,
        input logic ex_hit,
        input logic ld_hit
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src_used && !src_zero) begin
            if (ex_hit) begin
                sel = FWD_ALU;
            end else if (ld_hit) begin
                sel = FWD_LD;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline (master) and the hazard scoreboard (slave).
// HAZARD_PERF_EN adds the stall_cycles / bubble_cycles counter outputs.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5
);
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_rd_we;
    logic              flush;
    logic              ld_done;
    logic [ADDR_W-1:0] ld_done_rd;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              ld_full;
`ifdef HAZARD_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       bubble_cycles;
`endif

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_rd_we, flush, ld_done, ld_done_rd,
`ifdef HAZARD_PERF_EN
        input  stall_cycles, bubble_cycles,
`endif
        input  pc_stall, ifid_stall, idex_bubble, fwd_a, fwd_b, ld_full
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_rd_we, flush, ld_done, ld_done_rd,
`ifdef HAZARD_PERF_EN
        output stall_cycles, bubble_cycles,
`endif
        output pc_stall, ifid_stall, idex_bubble, fwd_a, fwd_b, ld_full
    );

endinterface

// File: rtl/hazard_load_tracker.sv
// Per-register pending-load bitmap and outstanding-load counter.
// Source busy flags see a completing load as already done (same-cycle clear bypass).
module hazard_load_tracker #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int MAX_LOADS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              ld_done,
    input  logic [ADDR_W-1:0] ld_done_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_pending,
    output logic              ld_full
);

    localparam int CNT_W = $clog2(MAX_LOADS + 1);

    logic [NUM_REGS-1:1] pending_reg;
    logic [NUM_REGS-1:1] pending_next;
    logic [NUM_REGS-1:0] pending_full;
    logic [CNT_W-1:0]    ld_cnt_reg;
    logic [CNT_W-1:0]    ld_cnt_next;
    logic                clr_hit;

    // x0 is never tracked, so bit 0 of the lookup vector is tied low.
    assign pending_full = {pending_reg, 1'b0};
    assign clr_hit      = ld_done && (ld_done_rd != '0) && pending_full[ld_done_rd];

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_pending
            assign pending_next[gi] =
                (pending_reg[gi] && !(clr_hit && (ld_done_rd == ADDR_W'(gi)))) ||
                (set_en && (set_rd == ADDR_W'(gi)));
        end
    endgenerate

    always_comb begin
        ld_cnt_next = ld_cnt_reg;
        if (set_en && !clr_hit) begin
            ld_cnt_next = ld_cnt_reg + 1'b1;
        end else if (!set_en && clr_hit) begin
            ld_cnt_next = ld_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            ld_cnt_reg  <= '0;
        end else begin
            pending_reg <= pending_next;
            ld_cnt_reg  <= ld_cnt_next;
        end
    end

    assign rs1_busy   = pending_full[rs1] && !(clr_hit && (ld_done_rd == rs1));
    assign rs2_busy   = pending_full[rs2] && !(clr_hit && (ld_done_rd == rs2));
    assign rd_pending = pending_full[rd];
    assign ld_full    = (ld_cnt_reg == CNT_W'(MAX_LOADS));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: load scoreboard stalls, branch-compare stalls, EX forwarding selects.
// Define HAZARD_PERF_EN to add free-running stall_cycles / bubble_cycles counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int MAX_LOADS = 2
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave hif
);

    logic              is_load;
    logic              is_branch;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_pending;
    logic              ld_full;
    logic              raw_load;
    logic              br_hazard;
    logic              struct_load;
    logic              waw_load;
    logic              stall;
    logic              issue;
    logic              load_set;
    logic [ADDR_W-1:0] ex_rd_reg;
    logic              ex_we_reg;
    logic              ex_is_load_reg;
    fwd_sel_e          fwd_a_reg;
    fwd_sel_e          fwd_b_reg;
    fwd_sel_e          fwd_a_next;
    fwd_sel_e          fwd_b_next;

    assign is_load   = (hif.id_opcode == OP_LOAD);
    assign is_branch = (hif.id_opcode == OP_BRANCH);
    assign load_set  = issue && is_load && hif.id_rd_we && (hif.id_rd != '0);

    hazard_load_tracker #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .MAX_LOADS (MAX_LOADS)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .set_en     (load_set),
        .set_rd     (hif.id_rd),
        .ld_done    (hif.ld_done),
        .ld_done_rd (hif.ld_done_rd),
        .rs1        (hif.id_rs1),
        .rs2        (hif.id_rs2),
        .rd         (hif.id_rd),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_pending (rd_pending),
        .ld_full    (ld_full)
    );

    assign raw_load    = (hif.id_use_rs1 && rs1_busy) || (hif.id_use_rs2 && rs2_busy);
    // Branches resolve in decode, so they cannot wait for EX forwarding.
    assign br_hazard   = is_branch && ex_we_reg && (ex_rd_reg != '0) &&
                         ((hif.id_use_rs1 && (hif.id_rs1 == ex_rd_reg)) ||
                          (hif.id_use_rs2 && (hif.id_rs2 == ex_rd_reg)));
    assign struct_load = is_load && ld_full;
    assign waw_load    = is_load && rd_pending;

    assign stall = hif.id_valid && !hif.flush &&
                   (raw_load || br_hazard || struct_load || waw_load);
    assign issue = hif.id_valid && !stall && !hif.flush;

    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (issue) begin
            fwd_a_next = fwd_select(hif.id_use_rs1, hif.id_rs1 == '0,
                                    ex_we_reg && !ex_is_load_reg && (hif.id_rs1 == ex_rd_reg),
                                    hif.ld_done && (hif.id_rs1 == hif.ld_done_rd));
            fwd_b_next = fwd_select(hif.id_use_rs2, hif.id_rs2 == '0,
                                    ex_we_reg && !ex_is_load_reg && (hif.id_rs2 == ex_rd_reg),
                                    hif.ld_done && (hif.id_rs2 == hif.ld_done_rd));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_reg      <= '0;
            ex_we_reg      <= 1'b0;
            ex_is_load_reg <= 1'b0;
            fwd_a_reg      <= FWD_RF;
            fwd_b_reg      <= FWD_RF;
        end else begin
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
            if (issue) begin
                ex_rd_reg      <= hif.id_rd;
                ex_we_reg      <= hif.id_rd_we;
                ex_is_load_reg <= is_load;
            end else begin
                ex_rd_reg      <= '0;
                ex_we_reg      <= 1'b0;
                ex_is_load_reg <= 1'b0;
            end
        end
    end

    assign hif.pc_stall    = stall;
    assign hif.ifid_stall  = stall;
    assign hif.idex_bubble = stall;
    assign hif.fwd_a       = fwd_a_reg;
    assign hif.fwd_b       = fwd_b_reg;
    assign hif.ld_full     = ld_full;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] bubble_cycles_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg  <= '0;
            bubble_cycles_reg <= '0;
        end else begin
            if (stall) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (stall || hif.flush) begin
                bubble_cycles_reg <= bubble_cycles_reg + 32'd1;
            end
        end
    end

    assign hif.stall_cycles  = stall_cycles_reg;
    assign hif.bubble_cycles = bubble_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: reference model pushes expected forwarding selects to a
// queue per decode transaction; they are popped when the registered outputs appear.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NUM_REGS  = 32;
    localparam int ADDR_W    = 5;
    localparam int MAX_LOADS = 2;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    typedef struct {
        logic        valid;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        we;
    } instr_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
    } fwd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.ADDR_W(ADDR_W)) hif();

    hazard_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .MAX_LOADS (MAX_LOADS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    fwd_exp_t   fwd_q[$];
    bit         pend [NUM_REGS];
    int         cnt;
    logic [4:0] m_ex_rd;
    bit         m_ex_we;
    bit         m_ex_ld;
    int         vectors;
    int         miscompares;
    int         txn_no;
    int         stall_seen;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic instr_t i_nop();
        instr_t i;
        i.valid = 1'b0; i.op = 7'd0; i.rs1 = 5'd0; i.rs2 = 5'd0;
        i.use1 = 1'b0; i.use2 = 1'b0; i.rd = 5'd0; i.we = 1'b0;
        return i;
    endfunction

    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i;
        i.valid = 1'b1; i.op = OP_ALU; i.rs1 = rs1; i.rs2 = rs2;
        i.use1 = 1'b1; i.use2 = 1'b1; i.rd = rd; i.we = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i.valid = 1'b1; i.op = OP_LOAD; i.rs1 = rs1; i.rs2 = 5'd0;
        i.use1 = 1'b1; i.use2 = 1'b0; i.rd = rd; i.we = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_br(input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i;
        i.valid = 1'b1; i.op = OP_BRANCH; i.rs1 = rs1; i.rs2 = rs2;
        i.use1 = 1'b1; i.use2 = 1'b1; i.rd = 5'd0; i.we = 1'b0;
        return i;
    endfunction

    function automatic bit m_busy(input logic [4:0] r, input bit done, input logic [4:0] drd);
        return (r != 5'd0) && pend[r] && !(done && (drd == r));
    endfunction

    function automatic logic [1:0] m_fwd(input bit used, input logic [4:0] r, input bit done,
                                         input logic [4:0] drd);
        if (!used || r == 5'd0) return 2'b00;
        if (m_ex_we && !m_ex_ld && r == m_ex_rd) return 2'b01;
        if (done && r == drd) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
        cnt     = 0;
        m_ex_rd = 5'd0;
        m_ex_we = 1'b0;
        m_ex_ld = 1'b0;
        fwd_q.delete();
    endtask

    task automatic drive_idle();
        hif.id_valid = 1'b0; hif.id_opcode = 7'd0; hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
        hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0; hif.id_rd = 5'd0; hif.id_rd_we = 1'b0;
        hif.flush = 1'b0; hif.ld_done = 1'b0; hif.ld_done_rd = 5'd0;
    endtask

    task automatic step(input instr_t t, input bit done = 1'b0, input logic [4:0] drd = 5'd0,
                        input bit fl = 1'b0);
        fwd_exp_t e;
        fwd_exp_t n;
        bit raw, br, st, waw, stall_m, issue_m, clr, set_m;
        @(negedge clk);
        if (fwd_q.size() > 0) begin
            e = fwd_q.pop_front();
            check_value("fwd_a", 32'(hif.fwd_a), 32'(e.a));
            check_value("fwd_b", 32'(hif.fwd_b), 32'(e.b));
        end
        check_value("ld_full", 32'(hif.ld_full), 32'(cnt == MAX_LOADS));
        hif.id_valid = t.valid; hif.id_opcode = t.op; hif.id_rs1 = t.rs1; hif.id_rs2 = t.rs2;
        hif.id_use_rs1 = t.use1; hif.id_use_rs2 = t.use2; hif.id_rd = t.rd; hif.id_rd_we = t.we;
        hif.flush = fl; hif.ld_done = done; hif.ld_done_rd = drd;
        #1;
        raw = (t.use1 && m_busy(t.rs1, done, drd)) || (t.use2 && m_busy(t.rs2, done, drd));
        br  = (t.op == OP_BRANCH) && m_ex_we && (m_ex_rd != 5'd0) &&
              ((t.use1 && t.rs1 == m_ex_rd) || (t.use2 && t.rs2 == m_ex_rd));
        st  = (t.op == OP_LOAD) && (cnt == MAX_LOADS);
        waw = (t.op == OP_LOAD) && (t.rd != 5'd0) && pend[t.rd];
        stall_m = t.valid && !fl && (raw || br || st || waw);
        issue_m = t.valid && !stall_m && !fl;
        check_value("stall", 32'({hif.pc_stall, hif.ifid_stall, hif.idex_bubble}), 32'({3{stall_m}}));
        if (hif.pc_stall) stall_seen++;
        txn_no++;
        $display("txn %0d: v=%0d op=%b rs1=x%0d rs2=x%0d rd=x%0d flush=%0d ld_done=%0d/x%0d -> stall=%0d ld_full=%0d",
                 txn_no, t.valid, t.op, t.rs1, t.rs2, t.rd, fl, done, drd, hif.pc_stall, hif.ld_full);
        n.a = issue_m ? m_fwd(t.use1, t.rs1, done, drd) : 2'b00;
        n.b = issue_m ? m_fwd(t.use2, t.rs2, done, drd) : 2'b00;
        fwd_q.push_back(n);
        clr   = done && (drd != 5'd0) && pend[drd];
        set_m = issue_m && (t.op == OP_LOAD) && (t.rd != 5'd0) && t.we;
        if (clr) begin pend[drd] = 1'b0; cnt--; end
        if (set_m) begin pend[t.rd] = 1'b1; cnt++; end
        m_ex_rd = issue_m ? t.rd : 5'd0;
        m_ex_we = issue_m ? t.we : 1'b0;
        m_ex_ld = issue_m ? (t.op == OP_LOAD) : 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; txn_no = 0; stall_seen = 0;
        drive_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_value("reset_stall", 32'({hif.pc_stall, hif.ifid_stall, hif.idex_bubble}), 32'd0);
        check_value("reset_fwd", 32'({hif.fwd_a, hif.fwd_b}), 32'd0);
        check_value("reset_ld_full", 32'(hif.ld_full), 32'd0);
        rst = 1'b0;

        // Load-use with a 3-cycle cache: two stall cycles, release on ld_done, fwd_a = LD.
        step(i_ld(5, 2));
        stall_seen = 0;
        step(i_alu(6, 5, 1));
        step(i_alu(6, 5, 1));
        step(i_alu(6, 5, 1), 1'b1, 5'd5);
        check_value("ld_use_stall_cycles", 32'(stall_seen), 32'd2);
        @(posedge clk); #1;
        check_value("ld_use_fwd_a", 32'(hif.fwd_a), 32'(FWD_LD));
        step(i_nop());

        // Branch right behind its ALU producer: exactly one stall.
        stall_seen = 0;
        step(i_alu(7, 1, 2));
        step(i_br(7, 0));
        step(i_br(7, 0));
        check_value("br_stall_cycles", 32'(stall_seen), 32'd1);
        @(posedge clk); #1;
        check_value("br_fwd_a", 32'(hif.fwd_a), 32'(FWD_RF));
        step(i_nop());

        // Structural limit: third load waits for a completion, then refills the count.
        step(i_ld(1, 0));
        step(i_ld(2, 0));
        stall_seen = 0;
        step(i_ld(3, 0));
        step(i_ld(3, 0));
        step(i_ld(3, 0), 1'b1, 5'd1);
        step(i_ld(3, 0));
        check_value("struct_stall_cycles", 32'(stall_seen), 32'd3);
        step(i_nop());
        check_value("struct_refull", 32'(hif.ld_full), 32'd1);
        step(i_nop(), 1'b1, 5'd2);
        step(i_nop(), 1'b1, 5'd3);
        step(i_nop());

        // WAW on a pending load destination; bit re-sets after the reissue.
        step(i_ld(4, 0));
        stall_seen = 0;
        step(i_ld(4, 0));
        step(i_ld(4, 0));
        step(i_ld(4, 0), 1'b1, 5'd4);
        step(i_ld(4, 0));
        check_value("waw_stall_cycles", 32'(stall_seen), 32'd3);
        step(i_alu(8, 4, 0));
        check_value("waw_repend_stall", 32'(hif.pc_stall), 32'd1);
        step(i_alu(8, 4, 0), 1'b1, 5'd4);
        step(i_nop());

        // Spurious completion must not decrement; flush squashes a hazarded instruction.
        step(i_ld(10, 0));
        step(i_nop(), 1'b1, 5'd9);
        step(i_ld(11, 0));
        step(i_nop());
        check_value("spurious_done_cnt", 32'(hif.ld_full), 32'd1);
        step(i_alu(12, 10, 0), 1'b0, 5'd0, 1'b1);
        check_value("flush_no_stall", 32'(hif.pc_stall), 32'd0);
        stall_seen = 0;
        step(i_br(12, 0));
        check_value("flush_clears_ex", 32'(stall_seen), 32'd0);
        step(i_nop(), 1'b1, 5'd10);
        step(i_nop(), 1'b1, 5'd11);
        step(i_nop());

        // Asynchronous reset in the middle of a stall with two loads outstanding.
        step(i_ld(1, 0));
        step(i_ld(2, 0));
        step(i_alu(5, 0, 0));
        step(i_alu(6, 5, 0));
        step(i_alu(7, 1, 0));
        #1 rst = 1'b1;
        #1;
        check_value("async_rst_stall", 32'({hif.pc_stall, hif.ifid_stall, hif.idex_bubble}), 32'd0);
        check_value("async_rst_fwd", 32'({hif.fwd_a, hif.fwd_b}), 32'd0);
        check_value("async_rst_ld_full", 32'(hif.ld_full), 32'd0);
        drive_idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(i_alu(7, 1, 0));
        step(i_nop());
        step(i_nop());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order RISC-V pipeline, placed between decode and the ID/EX register. It replaces fixed single-cycle load-use detection with a per-register scoreboard, so variable-latency data-cache loads are tracked until their completion handshake. It also bounds outstanding loads, stalls branches that compare in decode, and produces registered forwarding selects for the EX stage.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; x0 never tracked.
- ADDR_W, $clog2(NUM_REGS), register address width.
- MAX_LOADS, 2, maximum outstanding loads (1..NUM_REGS-1).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode holds a valid instruction.
- id_opcode  in  7  decode opcode (package constants).
- id_rs1, id_rs2  in  ADDR_W  decode source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- id_rd  in  ADDR_W  decode destination.
- id_rd_we  in  1  decode writes rd.
- flush  in  1  branch taken or redirect; the decode instruction is squashed.
- ld_done  in  1  data cache returns load data this cycle (MEM/WB).
- ld_done_rd  in  ADDR_W  destination of the completing load.
- pc_stall, ifid_stall  out  1  hold PC and the IF/ID register.
- idex_bubble  out  1  load a NOP into ID/EX.
- fwd_a, fwd_b  out  2  registered EX operand select: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB load.
- ld_full  out  1  outstanding load count equals MAX_LOADS.

## Operation
- State: pending[NUM_REGS-1:1] bitmap; ld_cnt in 0..MAX_LOADS; ex_rd/ex_we/ex_is_load, the destination of the instruction currently in EX.
- stall = id_valid & !flush & (raw_load | br_hazard | struct_load | waw_load).
  - raw_load: a used source is nonzero and pending, and not cleared this cycle by ld_done.
  - br_hazard: opcode is BRANCH, ex_we set, ex_rd nonzero, and ex_rd equals a used source.
  - struct_load: opcode is LOAD and ld_full.
  - waw_load: opcode is LOAD and pending[id_rd].
- pc_stall = ifid_stall = idex_bubble = stall.
- issue = id_valid & !stall & !flush. Flush forces a bubble without stalling PC.
- On issue of a LOAD with id_rd nonzero and id_rd_we: set pending[id_rd]; ld_cnt +1.
- On ld_done with ld_done_rd nonzero and pending: clear that bit; ld_cnt -1. If the bit is not pending, ignore the event (no underflow).
- When set and clear coincide on different registers, both apply and the net ld_cnt change is 0. Set and clear on the same register cannot coincide, because waw_load blocks it.
- ex_* register: loaded from id_* on issue; cleared on bubble or flush.
- fwd_x registered on issue:
  - 01 if the source equals ex_rd with ex_we set and not ex_is_load.
  - else 10 if the source equals ld_done_rd with ld_done set.
  - else 00.
  - Forced to 00 for x0, for unused sources, and on bubble.

## Timing
- Reset (asynchronous): pending=0, ld_cnt=0, ex_we=0, fwd_a=fwd_b=00. The stall outputs are 0 because they are derived from cleared state.
- Stall outputs are combinational, valid in the same cycle as the decode inputs.
- The load-use penalty equals the cache latency minus 1. The stall releases in the cycle ld_done is seen (same-cycle clear bypass), and the consumer takes 10 forwarding.
- A branch behind an ALU producer stalls exactly 1 cycle.
- Reset mid-operation discards all pending state; loads still in flight at the cache must be killed by the cache's own reset.

## Configuration
- HAZARD_PERF_EN defined: adds stall_cycles and bubble_cycles outputs, 32-bit, free-running and wrapping, reset to 0. stall_cycles increments on each cycle stall is high; bubble_cycles increments on stall or flush.
- HAZARD_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package holds:
  - opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011);
  - fwd select encodings FWD_RF, FWD_ALU, FWD_LD.
- Sub-module hazard_load_tracker contains the pending bitmap, ld_cnt, ld_full, and the same-cycle clear bypass. The top level holds the stall logic, the ex_* register and the fwd registers.

## Test plan
- Load x5; add x6,x5,x1 next cycle; ld_done for x5 after 3 cycles. Expect stall high 2 cycles, release in the ld_done cycle, fwd_a=10.
- add x7 then beq x7,x0. Expect exactly 1 stall cycle; then fwd 01 for the branch's EX issue is not required, and fwd_a=00 after the stall.
- MAX_LOADS=2: loads to x1,x2 outstanding, then load x3. Expect ld_full=1 and stall until ld_done x1; then issue; ld_cnt returns to 2.
- Load x4 pending, then load x4 again. Expect a waw stall until ld_done x4; pending[4] is set again after the reissue.
- Spurious ld_done for x9 with x9 not pending. Expect ld_cnt unchanged. Then a flush with id_valid and a hazard present: expect stall=0 and ex_we=0 next cycle.
- Assert rst mid-stall with 2 loads pending. Expect all outputs at reset values immediately, without waiting for a clock edge.
